paula_floppy_drive_ctrl: RTL and testbench

//  Per-drive mechanical model for one emulated floppy unit.
//  - Latches the motor state on the select edge and tracks head position and side.
//  - Models spin-up, disk-change and write-protect status lines.
//  - Drives the motor_on / _sel_del handshake consumed by the downstream HD-ID

---
 rtl/paula_floppy_drive_ctrl_pkg.sv | 13 +
 rtl/paula_floppy_drive_ctrl_spinup.sv | 75 +++++++
 rtl/paula_floppy_drive_ctrl.sv | 93 +++++++++
 tb/tb_paula_floppy_drive_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paula_floppy_drive_ctrl_pkg.sv
// Shared definitions for the per-drive floppy mechanical model.
package paula_floppy_drive_ctrl_pkg;

    localparam int TRACKS_DEF = 80;
    localparam int TRACK_W    = 7;

    typedef enum logic [1:0] {
        SPIN_OFF = 2'd0,
        SPIN_RUN = 2'd1,
        SPIN_RDY = 2'd2
    } spin_state_e;

endpackage

// File: rtl/paula_floppy_drive_ctrl_spinup.sv
// Motor spin-up timer: OFF / SPIN / RDY with a tick counter.
module paula_floppy_spinup_timer
    import paula_floppy_drive_ctrl_pkg::*;
#(
    parameter int               CNT_W        = 20,
    parameter logic [CNT_W-1:0] SPINUP_TICKS = CNT_W'(3500)
) (
    input  logic clk,
    input  logic clk7_en,
    input  logic reset,
    input  logic motor_on,
    input  logic disk_inserted,
    output logic spun_up
);

    localparam logic [CNT_W-1:0] LAST = SPINUP_TICKS - CNT_W'(1);

    spin_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             spun_up_q;

    assign cnt_d   = cnt_q + CNT_W'(1);
    assign spun_up = spun_up_q;

    // RDY is entered on the tick the counter reaches LAST
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state_q   <= SPIN_OFF;
                cnt_q     <= '0;
                spun_up_q <= 1'b0;
            end else begin
                unique case (state_q)
                    SPIN_OFF: begin
                        cnt_q     <= '0;
                        spun_up_q <= 1'b0;
                        if (motor_on) state_q <= SPIN_RUN;
                    end
                    SPIN_RUN: begin
                        if (!motor_on) begin
                            state_q <= SPIN_OFF;
                            cnt_q   <= '0;
                        end else if (!disk_inserted) begin
                            cnt_q <= '0;
                        end else if (cnt_d == LAST) begin
                            state_q   <= SPIN_RDY;
                            spun_up_q <= 1'b1;
                            cnt_q     <= cnt_d;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    SPIN_RDY: begin
                        if (!motor_on) begin
                            state_q   <= SPIN_OFF;
                            cnt_q     <= '0;
                            spun_up_q <= 1'b0;
                        end else if (!disk_inserted) begin
                            state_q   <= SPIN_RUN;
                            cnt_q     <= '0;
                            spun_up_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= SPIN_OFF;
                        cnt_q     <= '0;
                        spun_up_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/paula_floppy_drive_ctrl.sv
// One emulated floppy unit: motor latch, head position, status lines.
module paula_floppy_drive_ctrl
    import paula_floppy_drive_ctrl_pkg::*;
#(
    parameter int               TRACKS       = TRACKS_DEF,
    parameter int               CNT_W        = 20,
    parameter logic [CNT_W-1:0] SPINUP_TICKS = CNT_W'(3500)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk7_en,
    input  logic               _sel,
    input  logic               _motor,
    input  logic               _step,
    input  logic               _dir,
    input  logic               _side,
    input  logic               disk_inserted,
    input  logic               disk_wp,
    output logic               motor_on,
    output logic               _sel_del,
    output logic               _ready,
    output logic               _tk0,
    output logic               _chng,
    output logic               _wprot,
    output logic [TRACK_W-1:0] track,
    output logic               side
);

    localparam logic [TRACK_W-1:0] TRACK_MAX = TRACK_W'(TRACKS - 1);

    logic               motor_on_q;
    logic               sel_del_q;
    logic               step_del_q;
    logic [TRACK_W-1:0] track_q;
    logic               side_q;
    logic               chng_q;
    logic               spun_up;
    logic               sel_fall;
    logic               step_rise;

    assign sel_fall  = !_sel && sel_del_q;
    assign step_rise = _step && !step_del_q && !_sel;

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                motor_on_q <= 1'b0;
                sel_del_q  <= 1'b1;
                step_del_q <= 1'b1;
                track_q    <= '0;
                side_q     <= 1'b0;
                chng_q     <= 1'b1;
            end else begin
                sel_del_q  <= _sel;
                step_del_q <= _step;
                side_q     <= ~_side;
                if (sel_fall) motor_on_q <= ~_motor;
                if (step_rise) begin
                    if (_dir) begin
                        if (track_q != '0) track_q <= track_q - 1'b1;
                    end else begin
                        if (track_q != TRACK_MAX) track_q <= track_q + 1'b1;
                    end
                end
                // medium absent keeps the latch set even over a step
                if (!disk_inserted) chng_q <= 1'b1;
                else if (step_rise) chng_q <= 1'b0;
            end
        end
    end

    paula_floppy_spinup_timer #(
        .CNT_W        (CNT_W),
        .SPINUP_TICKS (SPINUP_TICKS)
    ) u_spinup (
        .clk           (clk),
        .clk7_en       (clk7_en),
        .reset         (reset),
        .motor_on      (motor_on_q),
        .disk_inserted (disk_inserted),
        .spun_up       (spun_up)
    );

    assign motor_on = motor_on_q;
    assign _sel_del = sel_del_q;
    assign track    = track_q;
    assign side     = side_q;
    assign _ready   = ~spun_up | _sel;
    assign _tk0     = (track_q != '0) | _sel;
    assign _chng    = ~chng_q | _sel;
    assign _wprot   = ~(disk_inserted & disk_wp) | _sel;

endmodule

// File: tb/tb_paula_floppy_drive_ctrl.sv
// Directed bench for paula_floppy_drive_ctrl.
module tb_paula_floppy_drive_ctrl;

    localparam int SPIN = 3500;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk7_en;
    logic       _sel;
    logic       _motor;
    logic       _step;
    logic       _dir;
    logic       _side;
    logic       disk_inserted;
    logic       disk_wp;
    logic       motor_on;
    logic       _sel_del;
    logic       _ready;
    logic       _tk0;
    logic       _chng;
    logic       _wprot;
    logic [6:0] track;
    logic       side;

    int tests = 0;
    int fails = 0;

    paula_floppy_drive_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .clk7_en       (clk7_en),
        ._sel          (_sel),
        ._motor        (_motor),
        ._step         (_step),
        ._dir          (_dir),
        ._side         (_side),
        .disk_inserted (disk_inserted),
        .disk_wp       (disk_wp),
        .motor_on      (motor_on),
        ._sel_del      (_sel_del),
        ._ready        (_ready),
        ._tk0          (_tk0),
        ._chng         (_chng),
        ._wprot        (_wprot),
        .track         (track),
        .side          (side)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_pulse();
        _step = 1'b0;
        tick();
        _step = 1'b1;
        tick();
    endtask

    task automatic count_ready(input int limit, output int n);
        n = limit + 1;
        for (int k = 1; k <= limit; k++) begin
            tick();
            if (_ready === 1'b0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (motor_on !== 1'b0) begin
            fails++;
            $display("FAIL rst_motor got %b exp 0", motor_on);
        end
        tests++;
        if (_sel_del !== 1'b1 || track !== 7'd0 || side !== 1'b0) begin
            fails++;
            $display("FAIL rst_regs got sd=%b trk=%0d side=%b exp 1/0/0",
                     _sel_del, track, side);
        end
        tests++;
        if (_ready !== 1'b1 || _tk0 !== 1'b1 || _chng !== 1'b1 || _wprot !== 1'b1) begin
            fails++;
            $display("FAIL rst_gated got %b%b%b%b exp 1111", _ready, _tk0, _chng, _wprot);
        end
        _sel = 1'b0;
        #1;
        tests++;
        if (_ready !== 1'b1 || _tk0 !== 1'b0 || _chng !== 1'b0 || _wprot !== 1'b1) begin
            fails++;
            $display("FAIL rst_sel got rdy/tk0/chng/wp=%b%b%b%b exp 1001",
                     _ready, _tk0, _chng, _wprot);
        end
        _sel = 1'b1;
        tick();
    endtask

    task automatic test_motor_latch();
        _motor = 1'b0;
        _sel   = 1'b0;
        tick();
        tests++;
        if (motor_on !== 1'b1 || _sel_del !== 1'b0) begin
            fails++;
            $display("FAIL motor_on got m=%b sd=%b exp 1/0", motor_on, _sel_del);
        end
        _motor = 1'b1;
        _sel   = 1'b1;
        tick();
        tests++;
        if (motor_on !== 1'b1 || _sel_del !== 1'b1) begin
            fails++;
            $display("FAIL motor_hold got m=%b sd=%b exp 1/1", motor_on, _sel_del);
        end
        _sel = 1'b0;
        tick();
        tests++;
        if (motor_on !== 1'b0) begin
            fails++;
            $display("FAIL motor_off got %b exp 0", motor_on);
        end
        _sel = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_spinup();
        int n;
        bit early;
        _motor = 1'b0;
        _sel   = 1'b0;
        tick();
        count_ready(SPIN + 100, n);
        tests++;
        if (n !== SPIN) begin
            fails++;
            $display("FAIL spin_ticks got %0d exp %0d", n, SPIN);
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b1;
        _sel   = 1'b0;
        tick();
        tick();
        tests++;
        if (motor_on !== 1'b0 || _ready !== 1'b1) begin
            fails++;
            $display("FAIL spin_stop got m=%b rdy=%b exp 0/1", motor_on, _ready);
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b0;
        _sel   = 1'b0;
        tick();
        early = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (_ready !== 1'b1) early = 1'b1;
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b1;
        _sel   = 1'b0;
        tick();
        tick();
        tests++;
        if (early || motor_on !== 1'b0 || _ready !== 1'b1) begin
            fails++;
            $display("FAIL spin_drop got early=%b m=%b rdy=%b exp 0/0/1",
                     early, motor_on, _ready);
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b0;
        _sel   = 1'b0;
        tick();
        count_ready(SPIN + 100, n);
        tests++;
        if (n !== SPIN) begin
            fails++;
            $display("FAIL spin_restart got %0d exp %0d", n, SPIN);
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b1;
        _sel   = 1'b0;
        tick();
        _sel = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_stepping();
        _motor = 1'b1;
        _sel   = 1'b0;
        tick();
        _dir = 1'b0;
        for (int i = 0; i < 81; i++) step_pulse();
        tests++;
        if (track !== 7'd79 || _tk0 !== 1'b1) begin
            fails++;
            $display("FAIL step_in got trk=%0d tk0=%b exp 79/1", track, _tk0);
        end
        _dir = 1'b1;
        for (int i = 0; i < 79; i++) step_pulse();
        tests++;
        if (track !== 7'd0 || _tk0 !== 1'b0) begin
            fails++;
            $display("FAIL step_out got trk=%0d tk0=%b exp 0/0", track, _tk0);
        end
        step_pulse();
        tests++;
        if (track !== 7'd0) begin
            fails++;
            $display("FAIL step_sat0 got %0d exp 0", track);
        end
        _side = 1'b0;
        tick();
        tests++;
        if (side !== 1'b1) begin
            fails++;
            $display("FAIL side got %b exp 1", side);
        end
        _side = 1'b1;
        tick();
    endtask

    task automatic test_clk_enable();
        _dir    = 1'b0;
        clk7_en = 1'b0;
        _step   = 1'b0;
        tick();
        _step = 1'b1;
        tick();
        tick();
        clk7_en = 1'b1;
        tick();
        tests++;
        if (track !== 7'd0) begin
            fails++;
            $display("FAIL clk_en got %0d exp 0", track);
        end
    endtask

    task automatic test_change();
        _sel  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        _sel  = 1'b0;
        #1;
        tests++;
        if (_chng !== 1'b0) begin
            fails++;
            $display("FAIL chng_rst got %b exp 0", _chng);
        end
        tick();
        _dir = 1'b1;
        step_pulse();
        tests++;
        if (_chng !== 1'b1 || track !== 7'd0) begin
            fails++;
            $display("FAIL chng_clr got chng=%b trk=%0d exp 1/0", _chng, track);
        end
        disk_inserted = 1'b0;
        tick();
        disk_inserted = 1'b1;
        tests++;
        if (_chng !== 1'b0) begin
            fails++;
            $display("FAIL chng_set got %b exp 0", _chng);
        end
    endtask

    task automatic test_gating();
        disk_wp = 1'b1;
        #1;
        tests++;
        if (_tk0 !== 1'b0 || _chng !== 1'b0 || _wprot !== 1'b0) begin
            fails++;
            $display("FAIL gate_sel0 got tk0/chng/wp=%b%b%b exp 000", _tk0, _chng, _wprot);
        end
        _sel = 1'b1;
        #1;
        tests++;
        if (_ready !== 1'b1 || _tk0 !== 1'b1 || _chng !== 1'b1 || _wprot !== 1'b1) begin
            fails++;
            $display("FAIL gate_sel1 got %b%b%b%b exp 1111", _ready, _tk0, _chng, _wprot);
        end
        _dir = 1'b0;
        step_pulse();
        _sel = 1'b0;
        #1;
        tests++;
        if (track !== 7'd0 || _chng !== 1'b0) begin
            fails++;
            $display("FAIL gate_step got trk=%0d chng=%b exp 0/0", track, _chng);
        end
        tick();
        _dir = 1'b1;
        step_pulse();
        _step = 1'b0;
        tick();
        _step         = 1'b1;
        disk_inserted = 1'b0;
        tick();
        disk_inserted = 1'b1;
        tests++;
        if (_chng !== 1'b0) begin
            fails++;
            $display("FAIL simul got %b exp 0", _chng);
        end
        disk_wp = 1'b0;
    endtask

    task automatic test_reset_mid_spin();
        int n;
        _sel   = 1'b1;
        _motor = 1'b1;
        tick();
        _sel = 1'b0;
        tick();
        _dir = 1'b0;
        step_pulse();
        step_pulse();
        tests++;
        if (track !== 7'd2) begin
            fails++;
            $display("FAIL mid_pre got %0d exp 2", track);
        end
        _sel = 1'b1;
        tick();
        _motor = 1'b0;
        _sel   = 1'b0;
        tick();
        for (int i = 0; i < 50; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (motor_on !== 1'b0 || track !== 7'd0 || _sel_del !== 1'b1 || _ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst got m=%b trk=%0d sd=%b rdy=%b exp 0/0/1/1",
                     motor_on, track, _sel_del, _ready);
        end
        tick();
        count_ready(SPIN + 100, n);
        tests++;
        if (n !== SPIN) begin
            fails++;
            $display("FAIL mid_spin got %0d exp %0d", n, SPIN);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b0;
        clk7_en       = 1'b1;
        _sel          = 1'b1;
        _motor        = 1'b1;
        _step         = 1'b1;
        _dir          = 1'b1;
        _side         = 1'b1;
        disk_inserted = 1'b1;
        disk_wp       = 1'b0;
        #3;
        test_reset();
        test_motor_latch();
        test_spinup();
        test_stepping();
        test_clk_enable();
        test_change();
        test_gating();
        test_reset_mid_spin();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
